// File: rtl/usb_rx_packet_engine.sv
// Full-speed USB receive path: line synchronisers, NRZI decode, bit unstuffing,
// PID and CRC5/CRC16 checking, and a byte FIFO tagged with end-of-packet markers.
module usb_rx_packet_engine #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        d_plus_in,
  input  logic                        d_minus_in,
  output logic [7:0]                  rx_data,
  output logic                        rx_last,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic                        pkt_done,
  output logic [2:0]                  pkt_status,
  output logic                        rx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] SAMPLE_AT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_PID, S_DATA, S_EOP_WAIT, S_ERR_WAIT
  } state_e;

  typedef enum logic [2:0] {
    ST_OK = 3'd0, ST_CRC = 3'd1, ST_PID = 3'd2, ST_STUFF = 3'd3,
    ST_OVF = 3'd4, ST_SYNC = 3'd5, ST_SHORT = 3'd6
  } status_e;

  logic          dp_s1_q, dp_s2_q, dm_s1_q, dm_s2_q, dp_prev_q;
  logic [CW-1:0] cnt_q;
  logic          dp_edge, sample, se0, jst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_s1_q   <= 1'b1;
      dp_s2_q   <= 1'b1;
      dm_s1_q   <= 1'b0;
      dm_s2_q   <= 1'b0;
      dp_prev_q <= 1'b1;
      cnt_q     <= '0;
    end else begin
      dp_s1_q   <= d_plus_in;
      dp_s2_q   <= dp_s1_q;
      dm_s1_q   <= d_minus_in;
      dm_s2_q   <= dm_s1_q;
      dp_prev_q <= dp_s2_q;
      if (dp_edge || cnt_q == CNT_LAST) cnt_q <= '0;
      else                              cnt_q <= cnt_q + 1'b1;
    end
  end

  assign dp_edge = dp_s2_q ^ dp_prev_q;
  assign sample  = !dp_edge && (cnt_q == SAMPLE_AT);
  assign se0     = !dp_s2_q && !dm_s2_q;
  assign jst     = dp_s2_q && !dm_s2_q;

  state_e        state_q, state_d;
  status_e       status_q, status_d, err_code, fin_code;
  logic          level_q, level_d;
  logic [2:0]    ones_q, ones_d, bitcnt_q, bitcnt_d;
  logic [6:0]    sr_q, sr_d;
  logic [1:0]    mode_q, mode_d;
  logic [4:0]    crc5_q, crc5_d;
  logic [15:0]   crc16_q, crc16_d;
  logic [7:0]    stg_q, stg_d, push_data, byte_w;
  logic          stg_vld_q, stg_vld_d, ovf_q, ovf_d, done_q, done_d;
  logic          push, push_last, err_v, fin_v, bit_ok, dbit, crc_bad;
  logic          full, pop, ovf_now, wr_en;
  logic [AW:0]   count_q;

  assign crc_bad = (mode_q == 2'b01) ? (crc5_q != 5'b01100) :
                   (mode_q == 2'b11) ? (crc16_q != 16'h800D) : 1'b0;

  always_comb begin
    state_d   = state_q;
    level_d   = level_q;
    ones_d    = ones_q;
    bitcnt_d  = bitcnt_q;
    sr_d      = sr_q;
    mode_d    = mode_q;
    crc5_d    = crc5_q;
    crc16_d   = crc16_q;
    stg_d     = stg_q;
    stg_vld_d = stg_vld_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    status_d  = status_q;
    push      = 1'b0;
    push_data = stg_q;
    push_last = 1'b0;
    err_v     = 1'b0;
    err_code  = ST_OK;
    fin_v     = 1'b0;
    fin_code  = ST_OK;
    bit_ok    = 1'b0;
    dbit      = (dp_s2_q == level_q);
    byte_w    = {dbit, sr_q};

    unique case (state_q)
      S_IDLE: begin
        level_d   = 1'b1;
        ones_d    = '0;
        bitcnt_d  = '0;
        stg_vld_d = 1'b0;
        crc5_d    = '1;
        crc16_d   = '1;
        if (dp_prev_q && !dp_s2_q) state_d = S_SYNC;
      end
      S_SYNC, S_PID, S_DATA: begin
        if (sample) begin
          if (se0) begin
            if (state_q != S_DATA) begin
              err_v    = 1'b1;
              err_code = ST_SHORT;
            end else begin
              fin_v = 1'b1;
              if (bitcnt_q != '0) fin_code = ST_SHORT;
              else if (crc_bad)   fin_code = ST_CRC;
              push      = stg_vld_q;
              push_last = 1'b1;
              state_d   = S_EOP_WAIT;
            end
          end else begin
            level_d = dp_s2_q;
            // Seventh bit after six ones is the stuff slot: consumed, never shifted in.
            if (ones_q == 3'd6) begin
              if (dbit) begin
                err_v    = 1'b1;
                err_code = ST_STUFF;
              end else begin
                ones_d = '0;
              end
            end else begin
              ones_d = dbit ? ones_q + 3'd1 : '0;
              bit_ok = 1'b1;
            end
          end
        end
        if (bit_ok) begin
          sr_d     = byte_w[7:1];
          bitcnt_d = bitcnt_q + 3'd1;
          if (state_q == S_DATA) begin
            crc5_d  = {crc5_q[3:0], 1'b0} ^ ((dbit ^ crc5_q[4]) ? 5'h05 : 5'h00);
            crc16_d = {crc16_q[14:0], 1'b0} ^ ((dbit ^ crc16_q[15]) ? 16'h8005 : 16'h0000);
          end
          if (bitcnt_q == 3'd7) begin
            if (state_q == S_SYNC) begin
              if (byte_w != 8'h80) begin
                err_v    = 1'b1;
                err_code = ST_SYNC;
              end else begin
                state_d = S_PID;
              end
            end else if (state_q == S_PID) begin
              if (byte_w[7:4] != ~byte_w[3:0]) begin
                err_v     = 1'b1;
                err_code  = ST_PID;
                push      = 1'b1;
                push_data = byte_w;
                push_last = 1'b1;
              end else begin
                state_d   = S_DATA;
                stg_d     = byte_w;
                stg_vld_d = 1'b1;
                mode_d    = byte_w[1:0];
              end
            end else if (!mode_q[0]) begin
              err_v    = 1'b1;
              err_code = ST_SHORT;
            end else begin
              push      = stg_vld_q;
              stg_d     = byte_w;
              stg_vld_d = 1'b1;
            end
          end
        end
        if (err_v) begin
          if (stg_vld_q) begin
            push      = 1'b1;
            push_data = stg_q;
            push_last = 1'b1;
          end
          done_d   = 1'b1;
          status_d = err_code;
          state_d  = S_ERR_WAIT;
        end
      end
      S_ERR_WAIT: if (sample && se0) state_d = S_EOP_WAIT;
      S_EOP_WAIT: if (sample && jst) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase

    ovf_now = push && full && !pop;
    if (state_q == S_IDLE) ovf_d = 1'b0;
    else if (ovf_now)      ovf_d = 1'b1;
    if (fin_v) begin
      done_d   = 1'b1;
      status_d = (fin_code == ST_OK && (ovf_q || ovf_now)) ? ST_OVF : fin_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      status_q  <= ST_OK;
      level_q   <= 1'b1;
      ones_q    <= '0;
      bitcnt_q  <= '0;
      sr_q      <= '0;
      mode_q    <= '0;
      crc5_q    <= '1;
      crc16_q   <= '1;
      stg_q     <= '0;
      stg_vld_q <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      status_q  <= status_d;
      level_q   <= level_d;
      ones_q    <= ones_d;
      bitcnt_q  <= bitcnt_d;
      sr_q      <= sr_d;
      mode_q    <= mode_d;
      crc5_q    <= crc5_d;
      crc16_q   <= crc16_d;
      stg_q     <= stg_d;
      stg_vld_q <= stg_vld_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  logic [7:0]    mem_data_q [FIFO_DEPTH];
  logic          mem_last_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [7:0]    hold_data_q;
  logic          hold_last_q;

  assign full  = (count_q == FULL_CNT);
  assign pop   = rx_valid && rx_ready;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data_q[wptr_q] <= push_data;
      mem_last_q[wptr_q] <= push_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      hold_data_q <= '0;
      hold_last_q <= 1'b0;
    end else begin
      if (wr_en) wptr_q <= wptr_q + 1'b1;
      if (pop) begin
        rptr_q      <= rptr_q + 1'b1;
        hold_data_q <= mem_data_q[rptr_q];
        hold_last_q <= mem_last_q[rptr_q];
      end
      count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  assign rx_valid   = (count_q != '0);
  assign rx_data    = rx_valid ? mem_data_q[rptr_q] : hold_data_q;
  assign rx_last    = rx_valid ? mem_last_q[rptr_q] : hold_last_q;
  assign pkt_done   = done_q;
  assign pkt_status = status_q;
  assign rx_busy    = (state_q != S_IDLE);
  assign fifo_count = count_q;

endmodule

// File: tb/tb_usb_rx_packet_engine.sv
// Directed bench: builds raw packet bit lists, NRZI/stuff-encodes them onto D+/D-,
// and checks drained bytes and packet status against values derived from those lists.
module tb_usb_rx_packet_engine;
  localparam int CPB   = 8;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst, dp, dm, rx_ready;
  logic [7:0] rx_data;
  logic       rx_last, rx_valid, pkt_done, rx_busy;
  logic [2:0] pkt_status;
  logic [3:0] fifo_count;

  int checks = 0;
  int errors = 0;

  usb_rx_packet_engine #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .d_plus_in(dp), .d_minus_in(dm),
    .rx_data(rx_data), .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .pkt_done(pkt_done), .pkt_status(pkt_status), .rx_busy(rx_busy),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int         done_cnt = 0;
  logic [2:0] last_status = '0;
  logic [8:0] got_q[$];

  always @(negedge clk) begin
    if (pkt_done) begin
      done_cnt++;
      last_status = pkt_status;
    end
    if (rx_valid && rx_ready) got_q.push_back({rx_last, rx_data});
  end

  logic tx_bits[$];
  logic line_lvl = 1'b1;

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) tx_bits.push_back(b[i]);
  endtask

  task automatic start_pkt(input logic [7:0] pid);
    tx_bits.delete();
    add_byte(8'h80);
    add_byte(pid);
  endtask

  task automatic add_crc16();
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 16; i < tx_bits.size(); i++) begin
      fb = tx_bits[i] ^ c[15];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) tx_bits.push_back(~c[i]);
  endtask

  task automatic add_crc5();
    logic [4:0] c;
    logic       fb;
    c = 5'h1F;
    for (int i = 16; i < tx_bits.size(); i++) begin
      fb = tx_bits[i] ^ c[4];
      c  = {c[3:0], 1'b0} ^ (fb ? 5'h05 : 5'h00);
    end
    for (int i = 4; i >= 0; i--) tx_bits.push_back(~c[i]);
  endtask

  function automatic logic [7:0] exp_byte(input int k);
    logic [7:0] r;
    for (int j = 0; j < 8; j++) r[j] = tx_bits[8 + 8 * k + j];
    return r;
  endfunction

  function automatic logic [8:0] got_at(input int idx);
    if (idx < got_q.size()) return got_q[idx];
    return 9'bx;
  endfunction

  task automatic drive_level(input logic p, input logic m);
    dp = p;
    dm = m;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic drive_bits(input bit bad_stuff);
    int   ones;
    bit   injected;
    logic b;
    ones     = 0;
    injected = 0;
    for (int i = 0; i < tx_bits.size(); i++) begin
      b = tx_bits[i];
      if (!b) line_lvl = ~line_lvl;
      drive_level(line_lvl, ~line_lvl);
      ones = b ? ones + 1 : 0;
      if (ones == 6) begin
        if (bad_stuff && !injected) injected = 1;
        else line_lvl = ~line_lvl;
        drive_level(line_lvl, ~line_lvl);
        ones = 0;
      end
    end
  endtask

  task automatic drive_eop();
    drive_level(1'b0, 1'b0);
    drive_level(1'b0, 1'b0);
    line_lvl = 1'b1;
    drive_level(1'b1, 1'b0);
    drive_level(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; dp = 1'b1; dm = 1'b0; rx_ready = 1'b0;
    idle(4);
    checks++; if (rx_valid !== 1'b0)   begin errors++; $display("FAIL reset_rx_valid got %b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00)   begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data); end
    checks++; if (rx_last !== 1'b0)    begin errors++; $display("FAIL reset_rx_last got %b exp 0", rx_last); end
    checks++; if (pkt_done !== 1'b0)   begin errors++; $display("FAIL reset_pkt_done got %b exp 0", pkt_done); end
    checks++; if (pkt_status !== 3'd0) begin errors++; $display("FAIL reset_status got %0d exp 0", pkt_status); end
    checks++; if (rx_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    rst = 1'b0;
    idle(10);
  endtask

  task automatic test_ack();
    int base_d, base_g;
    base_d = done_cnt; base_g = got_q.size();
    rx_ready = 1'b1;
    start_pkt(8'hD2);
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL ack_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd0)   begin errors++; $display("FAIL ack_status got %0d exp 0", last_status); end
    checks++; if (got_q.size() - base_g != 1) begin errors++; $display("FAIL ack_nbytes got %0d exp 1", got_q.size() - base_g); end
    checks++; if (got_at(base_g) !== {1'b1, 8'hD2}) begin errors++; $display("FAIL ack_byte got %h exp %h", got_at(base_g), {1'b1, 8'hD2}); end
    checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL ack_busy got %b exp 0", rx_busy); end
  endtask

  task automatic test_data_crc();
    int base_d, base_g;
    base_d = done_cnt; base_g = got_q.size();
    start_pkt(8'hC3);
    add_byte(8'h01);
    add_crc16();
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL data_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd0)   begin errors++; $display("FAIL data_status got %0d exp 0", last_status); end
    checks++; if (got_q.size() - base_g != 4) begin errors++; $display("FAIL data_nbytes got %0d exp 4", got_q.size() - base_g); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_at(base_g + k) !== {k == 3, exp_byte(k)}) begin
        errors++; $display("FAIL data_byte%0d got %h exp %h", k, got_at(base_g + k), {k == 3, exp_byte(k)});
      end
    end
    base_d = done_cnt; base_g = got_q.size();
    tx_bits[16] = ~tx_bits[16];
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL crcerr_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd1)   begin errors++; $display("FAIL crcerr_status got %0d exp 1", last_status); end
    checks++; if (got_q.size() - base_g != 4) begin errors++; $display("FAIL crcerr_nbytes got %0d exp 4", got_q.size() - base_g); end
  endtask

  task automatic test_stuff();
    int base_d, base_g;
    base_d = done_cnt; base_g = got_q.size();
    start_pkt(8'hC3);
    add_byte(8'hFF);
    add_crc16();
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (last_status !== 3'd0) begin errors++; $display("FAIL stuffok_status got %0d exp 0", last_status); end
    checks++; if (got_at(base_g + 1) !== {1'b0, 8'hFF}) begin errors++; $display("FAIL stuffok_byte got %h exp %h", got_at(base_g + 1), {1'b0, 8'hFF}); end
    checks++; if (got_q.size() - base_g != 4) begin errors++; $display("FAIL stuffok_nbytes got %0d exp 4", got_q.size() - base_g); end
    base_d = done_cnt; base_g = got_q.size();
    drive_bits(1);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL stuffbad_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd3)   begin errors++; $display("FAIL stuffbad_status got %0d exp 3", last_status); end
    checks++; if (rx_busy !== 1'b1)       begin errors++; $display("FAIL stuffbad_errwait got %b exp 1", rx_busy); end
    drive_eop();
    idle(20);
    checks++; if (rx_busy !== 1'b0)       begin errors++; $display("FAIL stuffbad_idle got %b exp 0", rx_busy); end
    checks++; if (got_q.size() - base_g != 1) begin errors++; $display("FAIL stuffbad_nbytes got %0d exp 1", got_q.size() - base_g); end
    checks++; if (got_at(base_g) !== {1'b1, 8'hC3}) begin errors++; $display("FAIL stuffbad_byte got %h exp %h", got_at(base_g), {1'b1, 8'hC3}); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL stuffbad_once got %0d exp 1", done_cnt - base_d); end
  endtask

  task automatic test_pid_err();
    int base_d, base_g;
    base_d = done_cnt; base_g = got_q.size();
    start_pkt(8'hD3);
    add_byte(8'h00);
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL pid_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd2)   begin errors++; $display("FAIL pid_status got %0d exp 2", last_status); end
    checks++; if (got_q.size() - base_g != 1) begin errors++; $display("FAIL pid_nbytes got %0d exp 1", got_q.size() - base_g); end
    checks++; if (got_at(base_g) !== {1'b1, 8'hD3}) begin errors++; $display("FAIL pid_byte got %h exp %h", got_at(base_g), {1'b1, 8'hD3}); end
  endtask

  task automatic test_short();
    int base_d, base_g;
    base_d = done_cnt; base_g = got_q.size();
    start_pkt(8'hC3);
    tx_bits.push_back(1'b1);
    tx_bits.push_back(1'b0);
    tx_bits.push_back(1'b1);
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL short_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd6)   begin errors++; $display("FAIL short_status got %0d exp 6", last_status); end
    checks++; if (got_at(base_g) !== {1'b1, 8'hC3}) begin errors++; $display("FAIL short_byte got %h exp %h", got_at(base_g), {1'b1, 8'hC3}); end
  endtask

  task automatic test_overflow();
    int base_d, base_g;
    base_d = done_cnt; base_g = got_q.size();
    rx_ready = 1'b0;
    start_pkt(8'h4B);
    for (int i = 0; i < 12; i++) add_byte(8'(8'h10 + i));
    add_crc16();
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (fifo_count !== 4'd8)    begin errors++; $display("FAIL ovf_count got %0d exp 8", fifo_count); end
    checks++; if (last_status !== 3'd4)   begin errors++; $display("FAIL ovf_status got %0d exp 4", last_status); end
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL ovf_done got %0d exp 1", done_cnt - base_d); end
    rx_ready = 1'b1;
    idle(20);
    checks++; if (got_q.size() - base_g != 8) begin errors++; $display("FAIL ovf_nbytes got %0d exp 8", got_q.size() - base_g); end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (got_at(base_g + k) !== {1'b0, exp_byte(k)}) begin
        errors++; $display("FAIL ovf_byte%0d got %h exp %h", k, got_at(base_g + k), {1'b0, exp_byte(k)});
      end
    end
    checks++; if (rx_valid !== 1'b0 || fifo_count !== 4'd0) begin errors++; $display("FAIL ovf_drained valid %b count %0d exp 0 0", rx_valid, fifo_count); end
    checks++; if (rx_data !== 8'h16) begin errors++; $display("FAIL ovf_hold got %h exp 16", rx_data); end
  endtask

  task automatic test_reset_mid();
    int base_d, base_g;
    rx_ready = 1'b0;
    start_pkt(8'hC3);
    add_byte(8'hAA);
    add_byte(8'h55);
    drive_bits(0);
    idle(4);
    checks++; if (fifo_count !== 4'd2) begin errors++; $display("FAIL mid_count got %0d exp 2", fifo_count); end
    rst = 1'b1;
    #2;
    checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL mid_rst_count got %0d exp 0", fifo_count); end
    checks++; if (rx_valid !== 1'b0 || rx_busy !== 1'b0 || pkt_status !== 3'd0) begin
      errors++; $display("FAIL mid_rst_outs valid %b busy %b status %0d exp 0 0 0", rx_valid, rx_busy, pkt_status);
    end
    dp = 1'b1; dm = 1'b0; line_lvl = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(10);
    base_d = done_cnt; base_g = got_q.size();
    rx_ready = 1'b1;
    start_pkt(8'h69);
    for (int i = 0; i < 7; i++) tx_bits.push_back(i inside {0, 2, 4});
    for (int i = 0; i < 4; i++) tx_bits.push_back(i inside {0, 1});
    add_crc5();
    drive_bits(0);
    drive_eop();
    idle(20);
    checks++; if (done_cnt - base_d != 1) begin errors++; $display("FAIL tok_done got %0d exp 1", done_cnt - base_d); end
    checks++; if (last_status !== 3'd0)   begin errors++; $display("FAIL tok_status got %0d exp 0", last_status); end
    checks++; if (got_q.size() - base_g != 3) begin errors++; $display("FAIL tok_nbytes got %0d exp 3", got_q.size() - base_g); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (got_at(base_g + k) !== {k == 2, exp_byte(k)}) begin
        errors++; $display("FAIL tok_byte%0d got %h exp %h", k, got_at(base_g + k), {k == 2, exp_byte(k)});
      end
    end
  endtask

  initial begin
    test_reset();
    test_ack();
    test_data_crc();
    test_stuff();
    test_pid_err();
    test_short();
    test_overflow();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
